// File: rtl/gpu_pkg.sv
// Encodings and default widths shared by the scheduler, fetcher and LSU.
package gpu_pkg;

    localparam int DEFAULT_ADDR_BITS = 8;
    localparam int DEFAULT_DATA_BITS = 16;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [2:0] {
        FETCHER_IDLE     = 3'b000,
        FETCHER_FETCHING = 3'b001,
        FETCHER_FETCHED  = 3'b010
    } fetcher_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'b00,
        LSU_REQUESTING = 2'b01,
        LSU_WAITING    = 2'b10,
        LSU_DONE       = 2'b11
    } lsu_state_t;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped one-instruction-per-line storage: combinational lookup,
// single synchronous fill port, flush that clears every valid bit.
module icache_array
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int LINES     = 8
)
(
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 flush,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic                 rd_hit,
    output logic [DATA_BITS-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data
);

    localparam int IDX_BITS = $clog2(LINES);
    localparam int TAG_BITS = ADDR_BITS - IDX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    valid_d;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [DATA_BITS-1:0] data_q [LINES];

    logic [IDX_BITS-1:0] rd_idx;
    logic [TAG_BITS-1:0] rd_tag;
    logic [IDX_BITS-1:0] wr_idx;
    logic [TAG_BITS-1:0] wr_tag;

    assign rd_idx = rd_addr[IDX_BITS-1:0];
    assign rd_tag = rd_addr[ADDR_BITS-1:IDX_BITS];
    assign wr_idx = wr_addr[IDX_BITS-1:0];
    assign wr_tag = wr_addr[ADDR_BITS-1:IDX_BITS];

    assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_data = data_q[rd_idx];

    // Flush beats a simultaneous fill: the line's data lands but stays invalid.
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
            assign valid_d[gi] = flush ? 1'b0
                               : (valid_q[gi] | (wr_en && (wr_idx == IDX_BITS'(gi))));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/instruction_fetcher.sv
// Per-core fetch stage: serves current_pc from a small direct-mapped cache,
// falling back to the shared program-memory read channel on a miss.
module instruction_fetcher
    import gpu_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int PROGRAM_MEM_DATA_BITS = DEFAULT_DATA_BITS,
    parameter int CACHE_LINES           = 8,
    parameter int CACHE_ENABLE          = 1
)
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             cache_flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [15:0]                      hit_count
);

    localparam bit CACHE_ON = (CACHE_ENABLE != 0);

    fetcher_state_t                   state_q, state_d;
    logic                             mem_read_valid_q, mem_read_valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address_q, mem_read_address_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instruction_q, instruction_d;
    logic [15:0]                      hit_count_q, hit_count_d;

    core_state_t                      core_state_e;
    logic                             array_hit;
    logic                             cache_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] cache_data;
    logic                             cache_wr_en;

    assign core_state_e = core_state_t'(core_state);
    assign cache_hit    = CACHE_ON && array_hit;

    icache_array #(
        .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS (PROGRAM_MEM_DATA_BITS),
        .LINES     (CACHE_LINES)
    ) u_icache (
        .clk     (clk),
        .srst    (reset),
        .flush   (cache_flush),
        .rd_addr (current_pc),
        .rd_hit  (array_hit),
        .rd_data (cache_data),
        .wr_en   (cache_wr_en),
        .wr_addr (mem_read_address_q),
        .wr_data (mem_read_data)
    );

    always_comb begin
        state_d            = state_q;
        mem_read_valid_d   = mem_read_valid_q;
        mem_read_address_d = mem_read_address_q;
        instruction_d      = instruction_q;
        hit_count_d        = hit_count_q;
        cache_wr_en        = 1'b0;
        case (state_q)
            FETCHER_IDLE: begin
                if (core_state_e == CORE_FETCH) begin
                    if (cache_hit) begin
                        instruction_d = cache_data;
                        state_d       = FETCHER_FETCHED;
                        hit_count_d   = (hit_count_q == 16'hFFFF) ? hit_count_q
                                                                  : hit_count_q + 16'd1;
                    end else begin
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = current_pc;
                        state_d            = FETCHER_FETCHING;
                    end
                end
            end
            FETCHER_FETCHING: begin
                // The request address is still held, so it doubles as the fill address.
                if (mem_read_ready) begin
                    mem_read_valid_d = 1'b0;
                    instruction_d    = mem_read_data;
                    state_d          = FETCHER_FETCHED;
                    cache_wr_en      = CACHE_ON;
                end
            end
            FETCHER_FETCHED: begin
                if (core_state_e == CORE_DECODE) begin
                    state_d = FETCHER_IDLE;
                end
            end
            default: state_d = FETCHER_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= FETCHER_IDLE;
            mem_read_valid_q   <= 1'b0;
            mem_read_address_q <= '0;
            instruction_q      <= '0;
            hit_count_q        <= '0;
        end else begin
            state_q            <= state_d;
            mem_read_valid_q   <= mem_read_valid_d;
            mem_read_address_q <= mem_read_address_d;
            instruction_q      <= instruction_d;
            hit_count_q        <= hit_count_d;
        end
    end

    assign fetcher_state    = state_q;
    assign mem_read_valid   = mem_read_valid_q;
    assign mem_read_address = mem_read_address_q;
    assign instruction      = instruction_q;
    assign hit_count        = hit_count_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Randomized fetch sequences against a model that tracks which PC each cache
// line currently holds, plus a cache-disabled instance.
module tb_instruction_fetcher;
    import gpu_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int LINES = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          cache_flush;
    logic [2:0]    core_state;
    logic [AW-1:0] current_pc;
    logic          mem_read_ready;
    logic [DW-1:0] mem_read_data;
    logic          mem_read_valid;
    logic [AW-1:0] mem_read_address;
    logic [2:0]    fetcher_state;
    logic [DW-1:0] instruction;
    logic [15:0]   hit_count;

    logic [2:0]    cs_nc;
    logic [AW-1:0] pc_nc;
    logic          ready_nc;
    logic [DW-1:0] data_nc;
    logic          valid_nc;
    logic [AW-1:0] addr_nc;
    logic [2:0]    state_nc;
    logic [DW-1:0] instr_nc;
    logic [15:0]   hits_nc;

    instruction_fetcher #(
        .PROGRAM_MEM_ADDR_BITS (AW),
        .PROGRAM_MEM_DATA_BITS (DW),
        .CACHE_LINES           (LINES),
        .CACHE_ENABLE          (1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .cache_flush      (cache_flush),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction),
        .hit_count        (hit_count)
    );

    instruction_fetcher #(
        .PROGRAM_MEM_ADDR_BITS (AW),
        .PROGRAM_MEM_DATA_BITS (DW),
        .CACHE_LINES           (LINES),
        .CACHE_ENABLE          (0)
    ) dut_nc (
        .clk              (clk),
        .reset            (reset),
        .core_state       (cs_nc),
        .current_pc       (pc_nc),
        .cache_flush      (cache_flush),
        .mem_read_valid   (valid_nc),
        .mem_read_address (addr_nc),
        .mem_read_ready   (ready_nc),
        .mem_read_data    (data_nc),
        .fetcher_state    (state_nc),
        .instruction      (instr_nc),
        .hit_count        (hits_nc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: program memory contents and the PC resident in each line.
    logic [DW-1:0] mem [256];
    bit            line_valid [LINES];
    logic [AW-1:0] line_pc    [LINES];
    int            exp_hits;
    logic [DW-1:0] exp_instr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_flush();
        for (int i = 0; i < LINES; i++) line_valid[i] = 1'b0;
    endtask

    task automatic fetch(input logic [AW-1:0] pc, input int lat, input bit flush_on_fill);
        bit hit;
        int idx;
        idx = int'(pc) % LINES;
        hit = line_valid[idx] && (line_pc[idx] == pc);
        @(negedge clk);
        core_state = CORE_FETCH;
        current_pc = pc;
        @(posedge clk); #1;
        if (hit) begin
            exp_hits++;
            exp_instr = mem[pc];
            check("hit_state", fetcher_state, FETCHER_FETCHED);
            check("hit_no_req", mem_read_valid, 1'b0);
        end else begin
            check("miss_state", fetcher_state, FETCHER_FETCHING);
            check("miss_req", mem_read_valid, 1'b1);
            check("miss_addr", mem_read_address, pc);
            for (int k = 0; k < lat; k++) begin
                @(negedge clk);
                @(posedge clk); #1;
                check("req_held", mem_read_valid, 1'b1);
                check("addr_held", mem_read_address, pc);
            end
            @(negedge clk);
            mem_read_ready = 1'b1;
            mem_read_data  = mem[pc];
            cache_flush    = flush_on_fill;
            @(posedge clk); #1;
            exp_instr = mem[pc];
            if (flush_on_fill) begin
                model_flush();
            end else begin
                line_valid[idx] = 1'b1;
                line_pc[idx]    = pc;
            end
            check("fill_state", fetcher_state, FETCHER_FETCHED);
            check("fill_req_drop", mem_read_valid, 1'b0);
            @(negedge clk);
            mem_read_ready = 1'b0;
            cache_flush    = 1'b0;
            mem_read_data  = DW'($urandom);
        end
        check("instr", instruction, exp_instr);
        check("hit_count", hit_count, exp_hits);
        $display("fetch pc=%02h hit=%0d lat=%0d flush=%0d instr=%04h hits=%0d",
                 pc, hit, lat, flush_on_fill, instruction, hit_count);
        @(negedge clk);
        core_state = CORE_DECODE;
        @(posedge clk); #1;
        check("decode_idle", fetcher_state, FETCHER_IDLE);
        check("instr_kept", instruction, exp_instr);
        @(negedge clk);
        core_state = CORE_IDLE;
        @(posedge clk);
    endtask

    task automatic standalone_flush();
        @(negedge clk);
        cache_flush = 1'b1;
        @(posedge clk); #1;
        check("flush_state", fetcher_state, FETCHER_IDLE);
        @(negedge clk);
        cache_flush = 1'b0;
        model_flush();
        $display("flush");
    endtask

    initial begin
        reset = 1'b1; cache_flush = 1'b0; core_state = CORE_IDLE; current_pc = '0;
        mem_read_ready = 1'b0; mem_read_data = '0;
        cs_nc = CORE_IDLE; pc_nc = '0; ready_nc = 1'b0; data_nc = '0;
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        mem[8'h05] = 16'h3A7F;
        mem[8'h0D] = 16'h1111;
        mem[8'h10] = 16'hBEEF;
        model_flush();
        exp_hits = 0;
        exp_instr = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_state", fetcher_state, FETCHER_IDLE);
        check("rst_valid", mem_read_valid, 1'b0);
        check("rst_addr", mem_read_address, 0);
        check("rst_instr", instruction, 0);
        check("rst_hits", hit_count, 0);
        @(negedge clk);
        reset = 1'b0;

        fetch(8'h05, 3, 1'b0);   // cold miss
        fetch(8'h05, 0, 1'b0);   // warm hit
        check("warm_hits", hit_count, 1);
        fetch(8'h0D, 1, 1'b0);   // evicts 0x05
        fetch(8'h05, 2, 1'b0);   // must miss again
        fetch(8'h10, 1, 1'b1);   // fill collides with flush
        check("collide_instr", instruction, 16'hBEEF);
        fetch(8'h10, 1, 1'b0);   // line left invalid -> miss

        // Reset in the middle of a miss; a late response must be ignored.
        @(negedge clk);
        core_state = CORE_FETCH;
        current_pc = 8'h20;
        @(posedge clk); #1;
        check("mid_fetching", fetcher_state, FETCHER_FETCHING);
        @(negedge clk);
        reset = 1'b1;
        core_state = CORE_IDLE;
        @(posedge clk); #1;
        check("mid_rst_state", fetcher_state, FETCHER_IDLE);
        @(negedge clk);
        reset = 1'b0;
        mem_read_ready = 1'b1;
        mem_read_data = 16'hDEAD;
        @(posedge clk); #1;
        check("late_state", fetcher_state, FETCHER_IDLE);
        check("late_valid", mem_read_valid, 1'b0);
        check("late_instr", instruction, 0);
        check("late_hits", hit_count, 0);
        @(negedge clk);
        mem_read_ready = 1'b0;
        model_flush();
        exp_hits = 0;
        exp_instr = '0;
        fetch(8'h10, 0, 1'b0);   // reset emptied the cache
        fetch(8'h20, 1, 1'b0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 11) == 0) standalone_flush();
            fetch(AW'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 9) == 0);
        end

        // Cache disabled: every fetch goes to memory.
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            cs_nc = CORE_FETCH;
            pc_nc = 8'h02;
            @(posedge clk); #1;
            check("nc_state", state_nc, FETCHER_FETCHING);
            check("nc_req", valid_nc, 1'b1);
            check("nc_addr", addr_nc, 8'h02);
            @(negedge clk);
            ready_nc = 1'b1;
            data_nc  = mem[8'h02];
            @(posedge clk); #1;
            check("nc_fetched", state_nc, FETCHER_FETCHED);
            check("nc_instr", instr_nc, mem[8'h02]);
            check("nc_hits", hits_nc, 0);
            $display("nc fetch pc=02 instr=%04h hits=%0d", instr_nc, hits_nc);
            @(negedge clk);
            ready_nc = 1'b0;
            cs_nc = CORE_DECODE;
            @(posedge clk);
            @(negedge clk);
            cs_nc = CORE_IDLE;
            @(posedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetcher.md
Name: instruction_fetcher

Overview:
- Per-core instruction fetch stage, directly upstream of the core scheduler.
- Watches the scheduler's core_state. When core_state is FETCH, it returns the instruction at current_pc and reports FETCHED on fetcher_state.
- Contains a small direct-mapped instruction cache in front of the shared program-memory read channel, so loop bodies avoid the memory-controller round trip.

Parameters:
- PROGRAM_MEM_ADDR_BITS, 8, width of PC / program-memory address.
- PROGRAM_MEM_DATA_BITS, 16, instruction width.
- CACHE_LINES, 8, number of direct-mapped one-instruction lines; must be a power of two, ≥2.
- CACHE_ENABLE, 1, 0 = every fetch is a miss and no fills occur.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- core_state  in  3  scheduler state (IDLE=000, FETCH=001, DECODE=010, …)
- current_pc  in  PROGRAM_MEM_ADDR_BITS  PC to fetch; stable while core_state==FETCH
- cache_flush  in  1  invalidate all cache lines (kernel launch)
- mem_read_valid  out  1  program-memory read request
- mem_read_address  out  PROGRAM_MEM_ADDR_BITS  request address
- mem_read_ready  in  1  response valid for one cycle; data on mem_read_data
- mem_read_data  in  PROGRAM_MEM_DATA_BITS  returned instruction
- fetcher_state  out  3  IDLE=000, FETCHING=001, FETCHED=010
- instruction  out  PROGRAM_MEM_DATA_BITS  fetched instruction; valid while FETCHED and until next fetch
- hit_count  out  16  saturating count of cache hits since reset

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, hit_count=0.
  - All valid bits cleared.
  - Any outstanding memory request is abandoned; a mem_read_ready arriving after reset is ignored.
- Cache lookup:
  - index = current_pc[log2(CACHE_LINES)-1:0]; tag = remaining upper PC bits.
  - Hit = CACHE_ENABLE && valid[index] && tag match.
- State machine:
  - IDLE & core_state==FETCH & hit:
    - next cycle instruction<=line data, state FETCHED, hit_count+=1 (saturates at FFFF).
    - No memory request is issued. Total latency is 1 cycle.
  - IDLE & core_state==FETCH & miss:
    - next cycle mem_read_valid<=1, mem_read_address<=current_pc, state FETCHING.
  - IDLE otherwise: hold.
  - FETCHING:
    - mem_read_valid and address are held until mem_read_ready==1.
    - On that cycle, next edge: mem_read_valid<=0, instruction<=mem_read_data, state FETCHED.
    - If CACHE_ENABLE, also write the line (data, tag, valid=1).
    - Miss latency is 1 + memory latency. mem_read_ready is only sampled in FETCHING.
  - FETCHED:
    - When core_state==DECODE, go to IDLE next edge; instruction is retained.
    - Otherwise hold FETCHED.
- cache_flush:
  - Clears all valid bits at the next edge. It does not alter fetcher_state or an in-flight request.
  - If a fill completes in the same cycle as cache_flush, the fill data still goes to instruction, but the line is left invalid (flush wins).
  - A lookup in the same cycle as cache_flush uses the pre-flush valid bits.
- Back-to-back:
  - A new fetch cannot start in the cycle the fetcher leaves FETCHED.
  - The scheduler's DECODE→…→FETCH path guarantees ≥1 IDLE cycle.
- Aliasing: two PCs with the same index evict each other; no associativity.

Decomposition:
- Shared package gpu_pkg holds:
  - core_state encodings (IDLE…DONE, 3-bit), fetcher_state encodings (IDLE/FETCHING/FETCHED), LSU state encodings;
  - default address/data widths.
- The scheduler and the fetcher both import gpu_pkg; no literal state codes in either.
- Sub-module icache_array:
  - valid/tag/data storage for CACHE_LINES lines;
  - combinational read (hit, data);
  - synchronous write port and flush input;
  - reset clears valid.
- The FSM and counter stay in instruction_fetcher.

Test Plan:
- Cold miss: reset, core_state=FETCH, current_pc=0x05, memory replies 3 cycles later with 0x3A7F → mem_read_valid=1, address=0x05, held until ready; then fetcher_state=FETCHED, instruction=0x3A7F, hit_count=0.
- Warm hit: after the above, core_state DECODE then FETCH at pc=0x05 → FETCHED one cycle later, instruction=0x3A7F, mem_read_valid never asserted, hit_count=1.
- Conflict eviction with CACHE_LINES=8: fetch pc=0x05, then pc=0x0D (same index, data 0x1111), then pc=0x05 again → third fetch misses and issues address 0x05.
- Flush collision: assert cache_flush in the same cycle mem_read_ready returns 0xBEEF for pc=0x10 → instruction=0xBEEF, FETCHED; the next fetch of 0x10 misses.
- Reset mid-fetch: assert reset while FETCHING at pc=0x20, then pulse mem_read_ready after reset → fetcher_state=IDLE, mem_read_valid=0, instruction=0, cache stays empty.
- CACHE_ENABLE=0: repeated fetches of pc=0x02 → each issues a memory request; hit_count stays 0.
